// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT pipeline: default size, latency
// formula, sample types and the output index bit reversal.
package fft_pkg;

  localparam int N_DEFAULT = 3;

  typedef logic signed [15:0] fpt;
  typedef struct packed {
    fpt re;
    fpt im;
  } cpx;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_FLUSH
  } seq_state_e;

  function automatic int pipe_lat(input int n);
    return (1 << n) - 1 + n;
  endfunction

  // Reverses the low n bits of v; bits at and above n come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < n) r = r | (((v >> i) & 16'd1) << (n - 1 - i));
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_seq_ctrl_if.sv
// Sample handshake plus output-side qualifiers between the frame sequencer
// and the FFT datapath.
interface fft_seq_ctrl_if import fft_pkg::*; #(
  parameter int N = N_DEFAULT
) ();

  logic         in_valid;
  logic         in_ready;
  logic         start_ip;
  logic         smp_en;
  logic         out_valid;
  logic         out_first;
  logic [N-1:0] out_idx;

  modport master (
    output in_valid,
    input  in_ready, start_ip, smp_en, out_valid, out_first, out_idx
  );

  modport slave (
    input  in_valid,
    output in_ready, start_ip, smp_en, out_valid, out_first, out_idx
  );

endinterface

// File: rtl/fft_seq_ctrl_token_delay.sv
// Fixed-latency token shift register; a set clr_mask bit empties the matching
// entry as it is written, so tokens of an aborted frame never reach the output.
module token_delay import fft_pkg::*; #(
  parameter int DEPTH = pipe_lat(N_DEFAULT),
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [DEPTH-1:0] clr_mask,
  output logic [WIDTH-1:0] dout,
  output logic             any_valid
);

  logic [WIDTH-1:0] line_q [DEPTH];
  logic [WIDTH-1:0] line_d [DEPTH];

  always_comb begin
    line_d[0] = clr_mask[0] ? '0 : din;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = clr_mask[i] ? '0 : line_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) line_q[i] <= line_d[i];
    end
  end

  // The valid flag is the top bit of every entry.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | line_q[i][WIDTH-1];
  end

  assign dout = line_q[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Frame sequencer: accepts 2^N-sample frames, launches stage 1, tracks tokens
// through the pipeline latency and aborts/flushes frames cut by an input gap.
module fft_seq_ctrl import fft_pkg::*; #(
  parameter int N         = N_DEFAULT,
  parameter int PIPE_LAT  = pipe_lat(N),
  parameter int FLUSH_LEN = 1 << N
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_seq_ctrl_if.slave        bus,
  output logic                 frame_err,
  output logic [15:0]          frames_done,
  output logic                 busy
);

  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [N-1:0] CNT_LAST = '1;

  seq_state_e    state_q, state_d;
  logic [N-1:0]  icnt_q, icnt_d;
  logic [N-1:0]  ocnt_q, ocnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          in_ready_q, in_ready_d;
  logic          start_ip_q, start_ip_d;
  logic          smp_en_q, smp_en_d;
  logic          frame_err_q, frame_err_d;
  logic [15:0]   frames_done_q, frames_done_d;
  logic          acc;
  logic          abort;
  logic [PIPE_LAT-1:0] clr_mask;
  logic [1:0]    tok_out;
  logic          tok_any;
  logic [N-1:0]  idx_nat;

  assign acc = bus.in_valid & in_ready_q;

  // icnt wraps naturally at 2^N, which is exactly the frame boundary.
  always_comb begin
    state_d = state_q;
    icnt_d  = icnt_q;
    fcnt_d  = fcnt_q;
    abort   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (acc) begin
          icnt_d  = icnt_q + 1'b1;
          state_d = SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (acc) begin
          icnt_d = icnt_q + 1'b1;
        end else if (!bus.in_valid) begin
          if (icnt_q == '0) begin
            state_d = SEQ_IDLE;
          end else begin
            abort   = 1'b1;
            icnt_d  = '0;
            fcnt_d  = '0;
            state_d = SEQ_FLUSH;
          end
        end
      end
      SEQ_FLUSH: begin
        if (fcnt_q == FW'(FLUSH_LEN - 1)) state_d = SEQ_IDLE;
        else                               fcnt_d  = fcnt_q + 1'b1;
      end
      default: state_d = SEQ_IDLE;
    endcase

    in_ready_d  = (state_d != SEQ_FLUSH);
    start_ip_d  = acc & (icnt_q == '0);
    smp_en_d    = acc;
    frame_err_d = abort;
  end

  // The partial frame's icnt tokens are the newest entries after this shift.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < PIPE_LAT; i++) clr_mask[i] = abort && (i < int'(icnt_q));
  end

  token_delay #(.DEPTH(PIPE_LAT), .WIDTH(2)) u_token_delay (
    .clk       (clk),
    .reset     (reset),
    .din       ({smp_en_q, start_ip_q}),
    .clr_mask  (clr_mask),
    .dout      (tok_out),
    .any_valid (tok_any)
  );

  assign bus.out_valid = tok_out[1];
  assign bus.out_first = tok_out[0];

  always_comb begin
    ocnt_d        = ocnt_q;
    frames_done_d = frames_done_q;
    if (bus.out_first)      ocnt_d = {{(N-1){1'b0}}, 1'b1};
    else if (bus.out_valid) ocnt_d = ocnt_q + 1'b1;
    if (bus.out_valid && ocnt_q == CNT_LAST) frames_done_d = frames_done_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEQ_IDLE;
      icnt_q        <= '0;
      ocnt_q        <= '0;
      fcnt_q        <= '0;
      in_ready_q    <= 1'b0;
      start_ip_q    <= 1'b0;
      smp_en_q      <= 1'b0;
      frame_err_q   <= 1'b0;
      frames_done_q <= '0;
    end else begin
      state_q       <= state_d;
      icnt_q        <= icnt_d;
      ocnt_q        <= ocnt_d;
      fcnt_q        <= fcnt_d;
      in_ready_q    <= in_ready_d;
      start_ip_q    <= start_ip_d;
      smp_en_q      <= smp_en_d;
      frame_err_q   <= frame_err_d;
      frames_done_q <= frames_done_d;
    end
  end

  assign idx_nat      = bus.out_first ? '0 : ocnt_q;
  assign bus.out_idx  = N'(bitrev(16'(idx_nat), N));
  assign bus.in_ready = in_ready_q;
  assign bus.start_ip = start_ip_q;
  assign bus.smp_en   = smp_en_q;
  assign frame_err    = frame_err_q;
  assign frames_done  = frames_done_q;
  assign busy         = (state_q != SEQ_IDLE) | tok_any | smp_en_q;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Self-checking bench for fft_seq_ctrl: directed vector table, multi-cycle
// corner sequences and random traffic against a frame-level reference model.
module tb_fft_seq_ctrl;
  import fft_pkg::*;

  localparam int N     = 3;
  localparam int L     = 10;
  localparam int FL    = 8;
  localparam int FRAME = 8;
  localparam int MAXC  = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_err;
  logic [15:0] frames_done;
  logic        busy;

  fft_seq_ctrl_if #(.N(N)) bus ();

  fft_seq_ctrl #(.N(N), .PIPE_LAT(L), .FLUSH_LEN(FL)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_err   (frame_err),
    .frames_done (frames_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: frames are scheduled onto the output timeline only once complete.
  int cyc;
  bit m_ready;
  int flush_lo, flush_hi;
  int pend[$];
  int m_fd;
  int last_end;
  bit sch_valid[MAXC];
  bit sch_first[MAXC];
  int sch_idx[MAXC];
  bit sch_fd[MAXC];

  int cnt_ov, cnt_ferr, cnt_nrdy, cnt_start, cnt_smp, first_ov, last_ov, ferr_at, c0;

  typedef struct {
    bit iv;
    bit ov;
    bit of;
    int idx;
    bit st;
    int fd;
  } vec_t;

  vec_t tbl[23];
  int idx_seq[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int bitrev3(input int i);
    return (i % 2) * 4 + ((i / 2) % 2) * 2 + (i / 4);
  endfunction

  task automatic checkVal(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic clearModel();
    pend.delete();
    m_fd     = 0;
    m_ready  = 1'b0;
    flush_lo = -10;
    flush_hi = -11;
    last_end = -100;
    for (int i = 0; i < MAXC; i++) begin
      sch_valid[i] = 1'b0;
      sch_first[i] = 1'b0;
      sch_idx[i]   = 0;
      sch_fd[i]    = 1'b0;
    end
  endtask

  task automatic clearScen();
    cnt_ov = 0; cnt_ferr = 0; cnt_nrdy = 0; cnt_start = 0; cnt_smp = 0;
    first_ov = -1; last_ov = -1; ferr_at = -1; c0 = cyc;
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_in_ready"}, bus.in_ready, 0);
    checkVal({tag, "_start_ip"}, bus.start_ip, 0);
    checkVal({tag, "_smp_en"}, bus.smp_en, 0);
    checkVal({tag, "_out_valid"}, bus.out_valid, 0);
    checkVal({tag, "_out_first"}, bus.out_first, 0);
    checkVal({tag, "_out_idx"}, bus.out_idx, 0);
    checkVal({tag, "_frame_err"}, frame_err, 0);
    checkVal({tag, "_frames_done"}, frames_done, 0);
    checkVal({tag, "_busy"}, busy, 0);
  endtask

  task automatic checkOutput(input bit acc, input bit e_start, input bit e_ferr);
    checkVal("in_ready", bus.in_ready, m_ready);
    checkVal("start_ip", bus.start_ip, e_start);
    checkVal("smp_en", bus.smp_en, acc);
    checkVal("frame_err", frame_err, e_ferr);
    checkVal("out_valid", bus.out_valid, sch_valid[cyc]);
    checkVal("out_first", bus.out_first, sch_first[cyc]);
    checkVal("out_idx", bus.out_idx, sch_idx[cyc]);
    checkVal("frames_done", frames_done, m_fd);
    checkVal("busy", busy, (acc || !m_ready || cyc <= last_end));
  endtask

  // Drives in_valid for the current cycle, advances one clock and checks the next cycle.
  task automatic applyStimulus(input bit iv);
    bit acc, e_start, e_ferr;
    int t;
    if (cyc + L + 4 >= MAXC) begin
      $display("[TB] FAIL cycle_budget at cycle %0d: got %0d, limit %0d", cyc, cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    bus.in_valid = iv;
    acc     = iv && m_ready;
    e_start = acc && (pend.size() == 0);
    e_ferr  = 1'b0;
    if (acc) begin
      pend.push_back(cyc);
      if (pend.size() == FRAME) begin
        for (int i = 0; i < FRAME; i++) begin
          t = pend[i] + 1 + L;
          sch_valid[t] = 1'b1;
          sch_first[t] = (i == 0);
          sch_idx[t]   = bitrev3(i);
        end
        sch_fd[pend[FRAME-1] + L + 2] = 1'b1;
        last_end = pend[FRAME-1] + 1 + L;
        pend.delete();
      end
    end else if (m_ready && !iv && pend.size() != 0) begin
      e_ferr   = 1'b1;
      pend.delete();
      flush_lo = cyc + 1;
      flush_hi = cyc + FL;
    end
    @(posedge clk);
    #1;
    cyc++;
    m_ready = !(cyc >= flush_lo && cyc <= flush_hi);
    if (sch_fd[cyc]) m_fd = (m_fd + 1) % 65536;
    checkOutput(acc, e_start, e_ferr);
    if (bus.out_valid) begin
      cnt_ov++;
      if (first_ov < 0) first_ov = cyc - c0;
      last_ov = cyc - c0;
    end
    if (frame_err) begin
      cnt_ferr++;
      ferr_at = cyc - c0;
    end
    if (!bus.in_ready) cnt_nrdy++;
    if (bus.start_ip) cnt_start++;
    if (bus.smp_en) cnt_smp++;
  endtask

  // Called one step after a clock edge; leaves the bench at cycle 0 of a fresh run.
  task automatic resetDut();
    #2;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkAllZero("rst_async");
    clearModel();
    @(posedge clk);
    #1;
    checkVal("rst_hold_in_ready", bus.in_ready, 0);
    #3;
    reset = 1'b0;
    applyStimulus(1'b0);
    clearScen();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    cyc = 0;
    clearModel();
    clearScen();
    @(posedge clk);
    #1;
    checkAllZero("por");
    #3;
    reset = 1'b0;
    applyStimulus(1'b0);

    // Single frame, cycle-exact against the documented timeline.
    for (int i = 0; i < 23; i++) begin
      tbl[i].iv  = (i >= 2 && i <= 9);
      tbl[i].ov  = (i >= 13 && i <= 20);
      tbl[i].of  = (i == 13);
      tbl[i].idx = tbl[i].ov ? idx_seq[i-13] : 0;
      tbl[i].st  = (i == 3);
      tbl[i].fd  = (i >= 21) ? 1 : 0;
    end
    resetDut();
    for (int i = 0; i < 23; i++) begin
      checkVal("tbl_out_valid", bus.out_valid, tbl[i].ov);
      checkVal("tbl_out_first", bus.out_first, tbl[i].of);
      checkVal("tbl_out_idx", bus.out_idx, tbl[i].idx);
      checkVal("tbl_start_ip", bus.start_ip, tbl[i].st);
      checkVal("tbl_frames_done", frames_done, tbl[i].fd);
      applyStimulus(tbl[i].iv);
    end

    // Three back-to-back frames.
    resetDut();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < 24; i++) applyStimulus(1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0);
    checkVal("b2b_start_count", cnt_start, 3);
    checkVal("b2b_out_count", cnt_ov, 24);
    checkVal("b2b_first_out", first_ov, 13);
    checkVal("b2b_last_out", last_ov, 36);
    checkVal("b2b_frames_done", frames_done, 3);

    // Abort after 5 samples; in_valid held high through the flush is ignored.
    resetDut();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0);
    checkVal("abort_err_count", cnt_ferr, 1);
    checkVal("abort_err_cycle", ferr_at, 8);
    checkVal("abort_notready", cnt_nrdy, 8);
    checkVal("abort_smp_count", cnt_smp, 13);
    checkVal("abort_out_count", cnt_ov, 8);
    checkVal("abort_first_out", first_ov, 27);
    checkVal("abort_frames_done", frames_done, 1);

    // Abort of frame 2 while frame 1 is still in the pipeline.
    resetDut();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < 11; i++) applyStimulus(1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0);
    checkVal("inflight_err_count", cnt_ferr, 1);
    checkVal("inflight_out_count", cnt_ov, 8);
    checkVal("inflight_last_out", last_ov, 20);
    checkVal("inflight_frames_done", frames_done, 1);

    // Reset pulse while frame 1 is streaming out.
    resetDut();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0);
    checkVal("midrst_pre_out_valid", bus.out_valid, 1);
    resetDut();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0);
    checkVal("midrst_out_count", cnt_ov, 0);
    checkVal("midrst_frames_done", frames_done, 0);

    // frames_done wrap from 0xFFFF.
    resetDut();
    force dut.frames_done_q = 16'hFFFF;
    #1;
    release dut.frames_done_q;
    m_fd = 16'hFFFF;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0);
    checkVal("wrap_frames_done", frames_done, 0);

    // Random bursts: full frames, back-to-back runs, partial frames and noise.
    resetDut();
    for (int b = 0; b < 200; b++) begin
      int ones;
      int gaps;
      ones = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8 * int'($urandom_range(1, 3));
      gaps = $urandom_range(0, 12);
      for (int k = 0; k < ones; k++) applyStimulus(1'b1);
      for (int k = 0; k < gaps; k++) applyStimulus($urandom_range(0, 5) == 0);
    end
    for (int i = 0; i < 24; i++) applyStimulus(1'b0);
    checkVal("rand_idle_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_seq_ctrl.md
# fft_seq_ctrl

Frame sequencer for the radix-2 single-delay-feedback FFT pipeline. It accepts a stream of 2^N-sample frames through a valid/ready handshake and issues the one-cycle `start_ip` pulse to the first butterfly stage. It tracks every in-flight frame through the fixed pipeline latency and produces the output-side `out_valid`, `out_first` and bit-reversed `out_idx` qualifiers. On a mid-frame input gap it aborts the partial frame and flushes.

## Interface
- `N`, 3, log2 of FFT size; frame length is 2^N samples.
- `PIPE_LAT`, (1<<N)-1+N, cycles from the `start_ip` pulse to the first valid output sample.
- `FLUSH_LEN`, 1<<N, number of cycles `in_ready` is held low after an abort.
- `clk` input 1 clock.
- `reset` input 1 async active-high reset.
- `in_valid` input 1 source presents a sample.
- `in_ready` output 1 controller accepts a sample (registered).
- `start_ip` output 1 one-cycle pulse to stage 1, aligned with the registered sample 0.
- `smp_en` output 1 registered accept strobe (`in_valid & in_ready`, delayed 1 cycle) for the datapath input register.
- `out_valid` output 1 pipeline output sample is valid.
- `out_first` output 1 first output sample of a frame.
- `out_idx` output N natural frequency index of the current output (bit-reversed output counter).
- `frame_err` output 1 one-cycle pulse on abort.
- `frames_done` output 16 count of completed output frames, wraps at 2^16.
- `busy` output 1 high when not IDLE or any token is in flight.

## Operation
- Accept is `acc = in_valid & in_ready`. The input counter `icnt[N-1:0]` increments on `acc` and wraps at 2^N-1 -> 0.
- States:
  - IDLE: `in_ready`=1. On `acc`, `icnt`=1 -> RUN.
  - RUN: `in_ready`=1.
    - `acc` with `icnt`==2^N-1: frame complete. `icnt`=0, stay RUN.
    - `in_valid`=0 with `icnt`==0: -> IDLE.
    - `in_valid`=0 with `icnt`!=0: abort -> FLUSH.
  - FLUSH: `in_ready`=0 for `FLUSH_LEN` cycles (counter `fcnt`), then -> IDLE. `icnt` is cleared on entry.
- Back-to-back frames are supported with no bubble: sample 0 of frame k+1 directly follows sample 2^N-1 of frame k.
- `start_ip` and `smp_en` are registered versions of (`acc` & `icnt`==0) and `acc`.
- Token delay line, depth `PIPE_LAT`. Each entry holds {valid, first}. It shifts every cycle, input {`smp_en`, `start_ip`}, output {`out_valid`, `out_first`}.
- On abort, the newest k entries have valid cleared, where k = samples of the partial frame already in the line (≤ 2^N-1). This is done via a clear mask so that no output of the partial frame is ever flagged. Older frames' tokens are untouched and drain normally.
- Output counter `ocnt[N-1:0]`:
  - Set to 1 when `out_first`.
  - Otherwise increments when `out_valid`.
  - `out_idx` = bitrev(`out_first` ? 0 : `ocnt`).
- `frames_done` increments on the cycle `out_valid` & `ocnt`==2^N-1.

## Timing
- Reset values: `in_ready`=0 for the reset cycle and 1 from the first clock after deassertion; all other outputs 0; state IDLE; delay line cleared.
- Latency: sample 0 accepted at cycle t -> `start_ip` at t+1 -> `out_first` at t+1+`PIPE_LAT`.
- `frame_err` pulses on the cycle after the gap cycle. `in_ready` is 0 from that cycle for `FLUSH_LEN` cycles.
- A gap exactly at a frame boundary is not an error.
- Reset asserted mid-operation clears everything asynchronously. In-flight frames are lost and no `out_valid` follows.
- `in_valid` during FLUSH is ignored and not accepted.

## Structure
- Shared package `fft_pkg`: the `N` default and the `PIPE_LAT` formula as a constant function. The typedefs `fpt`/`cpx` stay there; this block does not use them.
- One sub-module, `token_delay`: parameterised width-2 shift register of depth `PIPE_LAT` with a per-entry valid-clear mask input.
- A `bitrev` function goes in `fft_pkg`.

## Test plan
Parameters for all scenarios: N=3, `PIPE_LAT`=10, `FLUSH_LEN`=8.
- Single frame: `in_valid` high for 8 cycles from t=2 -> `start_ip` at 3. `out_first` at 13. `out_valid` 13..20 with `out_idx` 0,4,2,6,1,5,3,7. `frames_done`=1 at 21.
- Three back-to-back frames (24 continuous accepts) -> `start_ip` at 3, 11, 19. `out_valid` continuous 13..36. `frames_done`=3.
- Abort: 5 samples, then `in_valid`=0 -> `frame_err` one cycle; `in_ready`=0 for 8 cycles; zero `out_valid` for that frame; new frame afterwards produces normal output.
- Abort while the previous frame is in flight: frame 1 complete, frame 2 cut after 3 samples -> frame 1 still outputs all 8 samples; nothing from frame 2.
- `reset` pulse during `out_valid` of frame 1 -> all outputs 0 immediately; `in_ready`=1 after release; `frames_done`=0.
- `frames_done` wrap: preload via 65536 frames or force -> 0xFFFF -> 0x0000.
